// File: rtl/ik_swift_host_bridge.sv
// ik_swift_host_bridge
//   Avalon-MM slave register bridge on the CPU side of the ik_swift solver.
//   Solver operands (DW-bit fixed point) are assembled from 32-bit LO/HI bus
//   writes and driven straight out to the solver. The bridge sequences the
//   solver's reset and enable, waits for ik_done, and captures the results and
//   the run length for readback. It raises irq on completion.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   address           word address (6 bits)
//   chipselect        slave select
//   write, writedata  write strobe and 32-bit data
//   read, readdata    read strobe; readdata is registered (1-cycle latency)
//   irq               done_sticky & irq_en
//   ik_en, ik_rst     solver enable / solver reset
//   ik_z              3 x DW base axis, z[i] = bits [DW*i +: DW]
//   ik_joint_type     NJ joint type bits
//   ik_dh_dyn_in      NJ x DW dh parameters to solver
//   ik_target         NJ x DW target coordinates
//   ik_done           solver done
//   ik_dh_dyn_out     NJ x DW updated dh parameters from solver
//   ik_delta          NJ x DW joint deltas from solver
//
// Controller states
//   state   | meaning
//   S_RESET | ik_rst held high for RST_CYCLES, ik_en low, busy
//   S_IDLE  | waiting for start; operand writes accepted
//   S_RUN   | ik_en high, cycle counter running, waiting for ik_done / timeout

module ik_swift_host_bridge #(
   parameter int DW         = 36,
   parameter int NJ         = 6,
   parameter int MAX_CYCLES = 1048576,
   parameter int RST_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic             read,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   output logic             ik_en,
   output logic             ik_rst,
   output logic [3*DW-1:0]  ik_z,
   output logic [NJ-1:0]    ik_joint_type,
   output logic [NJ*DW-1:0] ik_dh_dyn_in,
   output logic [NJ*DW-1:0] ik_target,
   input  logic             ik_done,
   input  logic [NJ*DW-1:0] ik_dh_dyn_out,
   input  logic [NJ*DW-1:0] ik_delta
);

   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [5:0] A_CTRL   = 6'h00;
   localparam logic [5:0] A_JTYPE  = 6'h01;
   localparam logic [5:0] A_CYCLES = 6'h38;

   // Operands occupy LO/HI word pairs starting on even addresses, so the pair
   // index is address[5:1] and address[0] selects HI.
   localparam int P_Z      = 1;
   localparam int P_DH_IN  = 4;
   localparam int P_TGT    = 10;
   localparam int P_DH_OUT = 16;
   localparam int P_DELTA  = 22;

   typedef enum logic [1:0] {S_RESET, S_IDLE, S_RUN} state_t;

   state_t          state;
   logic [RW-1:0]   rst_cnt;
   logic [CW-1:0]   run_cnt;
   logic [CW-1:0]   cycles_r;
   logic            done_sticky;
   logic            timeout;
   logic            irq_en;

   logic [DW-1:0]   z_r      [0:2];
   logic [DW-1:0]   dh_in_r  [0:NJ-1];
   logic [DW-1:0]   tgt_r    [0:NJ-1];
   logic [DW-1:0]   dh_out_r [0:NJ-1];
   logic [DW-1:0]   delta_r  [0:NJ-1];
   logic [NJ-1:0]   jtype_r;

   logic            wr_en, rd_en, ctrl_wr, soft_rst, start, clear, busy, op_wr;
   logic [4:0]      pair;
   logic            hi;
   logic [31:0]     rd_val;

   function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] v,
                                                input logic hi_sel,
                                                input logic [31:0] wd);
      logic [DW-1:0] m;
      m = v;
      if (hi_sel) m[DW-1:32] = wd[DW-33:0];
      else        m[31:0]    = wd;
      return m;
   endfunction

   // HI half reads back sign-extended from the operand's top bit.
   function automatic logic [31:0] read_word(input logic [DW-1:0] v,
                                             input logic hi_sel);
      if (hi_sel) return {{(64-DW){v[DW-1]}}, v[DW-1:32]};
      else        return v[31:0];
   endfunction

   assign wr_en    = chipselect & write;
   assign rd_en    = chipselect & read;
   assign ctrl_wr  = wr_en && (address == A_CTRL);
   assign soft_rst = ctrl_wr & writedata[1];
   assign start    = ctrl_wr & writedata[0] & ~writedata[1];
   assign clear    = ctrl_wr & writedata[3];
   assign busy     = (state != S_IDLE);
   assign op_wr    = wr_en & ~busy;
   assign pair     = address[5:1];
   assign hi       = address[0];
   assign irq      = done_sticky & irq_en;

   // Operand registers: only writable while the solver is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         jtype_r <= '0;
         for (int i = 0; i < 3; i++) z_r[i] <= '0;
         for (int i = 0; i < NJ; i++) begin
            dh_in_r[i] <= '0;
            tgt_r[i]   <= '0;
         end
      end else if (op_wr) begin
         if (address == A_JTYPE) jtype_r <= writedata[NJ-1:0];
         for (int i = 0; i < 3; i++)
            if (pair == 5'(P_Z + i)) z_r[i] <= merge_word(z_r[i], hi, writedata);
         for (int i = 0; i < NJ; i++) begin
            if (pair == 5'(P_DH_IN + i)) dh_in_r[i] <= merge_word(dh_in_r[i], hi, writedata);
            if (pair == 5'(P_TGT + i))   tgt_r[i]   <= merge_word(tgt_r[i], hi, writedata);
         end
      end
   end

   // Sequencer, status and result capture. Soft reset takes priority over a
   // coincident ik_done; a coincident ik_done takes priority over clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RESET;
         ik_rst      <= 1'b1;
         ik_en       <= 1'b0;
         rst_cnt     <= RW'(RST_CYCLES - 1);
         run_cnt     <= '0;
         cycles_r    <= '0;
         done_sticky <= 1'b0;
         timeout     <= 1'b0;
         irq_en      <= 1'b0;
         for (int i = 0; i < NJ; i++) begin
            dh_out_r[i] <= '0;
            delta_r[i]  <= '0;
         end
      end else begin
         if (ctrl_wr) irq_en <= writedata[2];
         if (clear) begin
            done_sticky <= 1'b0;
            timeout     <= 1'b0;
         end
         if (soft_rst) begin
            state   <= S_RESET;
            ik_rst  <= 1'b1;
            ik_en   <= 1'b0;
            rst_cnt <= RW'(RST_CYCLES - 1);
         end else begin
            case (state)
               S_RESET: begin
                  if (rst_cnt == '0) begin
                     state  <= S_IDLE;
                     ik_rst <= 1'b0;
                  end else begin
                     rst_cnt <= rst_cnt - 1'b1;
                  end
               end
               S_IDLE: begin
                  if (start) begin
                     state       <= S_RUN;
                     ik_en       <= 1'b1;
                     run_cnt     <= '0;
                     done_sticky <= 1'b0;
                     timeout     <= 1'b0;
                  end
               end
               S_RUN: begin
                  // run_cnt holds the number of completed RUN cycles, so the
                  // current cycle is run_cnt + 1.
                  if (ik_done) begin
                     for (int i = 0; i < NJ; i++) begin
                        dh_out_r[i] <= ik_dh_dyn_out[DW*i +: DW];
                        delta_r[i]  <= ik_delta[DW*i +: DW];
                     end
                     cycles_r    <= run_cnt + 1'b1;
                     done_sticky <= 1'b1;
                     ik_en       <= 1'b0;
                     state       <= S_IDLE;
                  end else if (run_cnt + 1'b1 == CW'(MAX_CYCLES)) begin
                     timeout <= 1'b1;
                     ik_en   <= 1'b0;
                     ik_rst  <= 1'b1;
                     rst_cnt <= RW'(RST_CYCLES - 1);
                     state   <= S_RESET;
                  end else begin
                     run_cnt <= run_cnt + 1'b1;
                  end
               end
               default: begin
                  state   <= S_RESET;
                  ik_rst  <= 1'b1;
                  ik_en   <= 1'b0;
                  rst_cnt <= RW'(RST_CYCLES - 1);
               end
            endcase
         end
      end
   end

   always_comb begin
      rd_val = '0;
      if (address == A_CTRL)   rd_val = {28'b0, irq_en, timeout, done_sticky, busy};
      if (address == A_JTYPE)  rd_val[NJ-1:0] = jtype_r;
      if (address == A_CYCLES) rd_val = 32'(cycles_r);
      for (int i = 0; i < 3; i++)
         if (pair == 5'(P_Z + i)) rd_val = read_word(z_r[i], hi);
      for (int i = 0; i < NJ; i++) begin
         if (pair == 5'(P_DH_IN + i))  rd_val = read_word(dh_in_r[i], hi);
         if (pair == 5'(P_TGT + i))    rd_val = read_word(tgt_r[i], hi);
         if (pair == 5'(P_DH_OUT + i)) rd_val = read_word(dh_out_r[i], hi);
         if (pair == 5'(P_DELTA + i))  rd_val = read_word(delta_r[i], hi);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)        readdata <= '0;
      else if (rd_en) readdata <= rd_val;
   end

   assign ik_joint_type = jtype_r;

   for (genvar g = 0; g < 3; g++) begin : g_z
      assign ik_z[DW*g +: DW] = z_r[g];
   end

   for (genvar g = 0; g < NJ; g++) begin : g_ops
      assign ik_dh_dyn_in[DW*g +: DW] = dh_in_r[g];
      assign ik_target[DW*g +: DW]    = tgt_r[g];
   end

endmodule

// File: tb/tb_ik_swift_host_bridge.sv
// Directed testbench for ik_swift_host_bridge. The DUT runs with a shortened
// MAX_CYCLES so the timeout path completes quickly while the 100-cycle run
// still finishes normally.

module tb_ik_swift_host_bridge;

   localparam int DW  = 36;
   localparam int NJ  = 6;
   localparam int MAXC = 128;

   logic             clk;
   logic             rst;
   logic [5:0]       address;
   logic             chipselect;
   logic             write;
   logic             read;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic             irq;
   logic             ik_en;
   logic             ik_rst;
   logic [3*DW-1:0]  ik_z;
   logic [NJ-1:0]    ik_joint_type;
   logic [NJ*DW-1:0] ik_dh_dyn_in;
   logic [NJ*DW-1:0] ik_target;
   logic             ik_done;
   logic [NJ*DW-1:0] ik_dh_dyn_out;
   logic [NJ*DW-1:0] ik_delta;

   int          n_pass;
   int          n_total;
   logic [31:0] rd;

   ik_swift_host_bridge #(
      .DW(DW), .NJ(NJ), .MAX_CYCLES(MAXC), .RST_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .address(address), .chipselect(chipselect),
      .write(write), .read(read), .writedata(writedata), .readdata(readdata),
      .irq(irq), .ik_en(ik_en), .ik_rst(ik_rst), .ik_z(ik_z),
      .ik_joint_type(ik_joint_type), .ik_dh_dyn_in(ik_dh_dyn_in),
      .ik_target(ik_target), .ik_done(ik_done), .ik_dh_dyn_out(ik_dh_dyn_out),
      .ik_delta(ik_delta)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus helpers: called at a negedge, occupy exactly one cycle, return at the
   // following negedge.
   task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clk);
      d = readdata;
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++;
      if (ik_rst !== 1'b1) $display("FAIL reset_ik_rst_c1: got %b want 1", ik_rst); else n_pass++;
      n_total++;
      if (ik_en !== 1'b0) $display("FAIL reset_ik_en: got %b want 0", ik_en); else n_pass++;
      n_total++;
      if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", readdata); else n_pass++;
      n_total++;
      if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
      n_total++;
      if ({ik_z, ik_joint_type, ik_dh_dyn_in, ik_target} !== '0)
         $display("FAIL reset_operands: got nonzero want 0"); else n_pass++;
      @(negedge clk);
      n_total++;
      if (ik_rst !== 1'b1) $display("FAIL reset_ik_rst_c2: got %b want 1", ik_rst); else n_pass++;
      @(negedge clk);
      n_total++;
      if (ik_rst !== 1'b0) $display("FAIL reset_ik_rst_c3: got %b want 0", ik_rst); else n_pass++;
      bus_read(6'h00, rd);
      n_total++;
      if (rd !== 32'h0) $display("FAIL reset_status: got %h want 0", rd); else n_pass++;
   endtask

   task automatic test_operand_write();
      bus_write(6'h02, 32'h0001_0000);
      bus_write(6'h03, 32'hFFFF_FFFF);
      n_total++;
      if (ik_z[35:0] !== 36'hF_0001_0000) $display("FAIL z0_out: got %h want F00010000", ik_z[35:0]); else n_pass++;
      n_total++;
      if (ik_z[71:36] !== 36'h0) $display("FAIL z1_untouched: got %h want 0", ik_z[71:36]); else n_pass++;
      bus_read(6'h03, rd);
      n_total++;
      if (rd !== 32'hFFFF_FFFF) $display("FAIL z0_hi_read: got %h want FFFFFFFF", rd); else n_pass++;
      bus_read(6'h02, rd);
      n_total++;
      if (rd !== 32'h0001_0000) $display("FAIL z0_lo_read: got %h want 00010000", rd); else n_pass++;
      bus_write(6'h01, 32'hFFFF_FFEA);
      n_total++;
      if (ik_joint_type !== 6'h2A) $display("FAIL jtype_out: got %h want 2A", ik_joint_type); else n_pass++;
      bus_read(6'h01, rd);
      n_total++;
      if (rd !== 32'h0000_002A) $display("FAIL jtype_read: got %h want 0000002A", rd); else n_pass++;
      bus_write(6'h1E, 32'hCAFE_F00D);
      bus_write(6'h1F, 32'h0000_0005);
      n_total++;
      if (ik_target[5*DW +: DW] !== 36'h5_CAFE_F00D)
         $display("FAIL target5_out: got %h want 5CAFEF00D", ik_target[5*DW +: DW]); else n_pass++;
      bus_read(6'h1F, rd);
      n_total++;
      if (rd !== 32'h0000_0005) $display("FAIL target5_hi_read: got %h want 00000005", rd); else n_pass++;
      bus_write(6'h08, 32'hAAAA_5555);
      bus_write(6'h09, 32'h0000_0003);
      n_total++;
      if (ik_dh_dyn_in[35:0] !== 36'h3_AAAA_5555)
         $display("FAIL dh_in0_out: got %h want 3AAAA5555", ik_dh_dyn_in[35:0]); else n_pass++;
      bus_read(6'h3A, rd);
      n_total++;
      if (rd !== 32'h0) $display("FAIL unmapped_read: got %h want 0", rd); else n_pass++;
   endtask

   task automatic test_run_done();
      ik_dh_dyn_out = '0;
      ik_delta      = '0;
      ik_dh_dyn_out[0 +: DW]    = 36'h8_0000_0001;
      ik_delta[1*DW +: DW]      = 36'h7_FFFF_FFFF;
      ik_delta[5*DW +: DW]      = 36'h0_1234_5678;
      bus_write(6'h00, 32'h5);
      n_total++;
      if (ik_en !== 1'b1) $display("FAIL run_en_c1: got %b want 1", ik_en); else n_pass++;
      repeat (99) @(negedge clk);
      n_total++;
      if (ik_en !== 1'b1) $display("FAIL run_en_c100: got %b want 1", ik_en); else n_pass++;
      ik_done = 1'b1;
      @(negedge clk);
      ik_done = 1'b0;
      n_total++;
      if (ik_en !== 1'b0) $display("FAIL run_en_after_done: got %b want 0", ik_en); else n_pass++;
      n_total++;
      if (irq !== 1'b1) $display("FAIL run_irq: got %b want 1", irq); else n_pass++;
      bus_read(6'h20, rd);
      n_total++;
      if (rd !== 32'h0000_0001) $display("FAIL dh_out0_lo: got %h want 00000001", rd); else n_pass++;
      bus_read(6'h21, rd);
      n_total++;
      if (rd !== 32'hFFFF_FFF8) $display("FAIL dh_out0_hi: got %h want FFFFFFF8", rd); else n_pass++;
      bus_read(6'h2E, rd);
      n_total++;
      if (rd !== 32'hFFFF_FFFF) $display("FAIL delta1_lo: got %h want FFFFFFFF", rd); else n_pass++;
      bus_read(6'h2F, rd);
      n_total++;
      if (rd !== 32'h0000_0007) $display("FAIL delta1_hi: got %h want 00000007", rd); else n_pass++;
      bus_read(6'h36, rd);
      n_total++;
      if (rd !== 32'h1234_5678) $display("FAIL delta5_lo: got %h want 12345678", rd); else n_pass++;
      bus_read(6'h38, rd);
      n_total++;
      if (rd !== 32'd100) $display("FAIL cycles_100: got %0d want 100", rd); else n_pass++;
      bus_read(6'h00, rd);
      n_total++;
      if (rd !== 32'hA) $display("FAIL status_done: got %h want A", rd); else n_pass++;
      bus_write(6'h00, 32'h8);
      n_total++;
      if (irq !== 1'b0) $display("FAIL irq_cleared: got %b want 0", irq); else n_pass++;
      bus_write(6'h20, 32'h0000_DEAD);
      bus_read(6'h20, rd);
      n_total++;
      if (rd !== 32'h0000_0001) $display("FAIL ro_write_ignored: got %h want 00000001", rd); else n_pass++;
   endtask

   task automatic test_busy_ignores();
      bus_write(6'h00, 32'h1);
      bus_write(6'h08, 32'h0000_1234);
      bus_write(6'h00, 32'h1);
      n_total++;
      if (ik_dh_dyn_in[35:0] !== 36'h3_AAAA_5555)
         $display("FAIL busy_dh_in_kept: got %h want 3AAAA5555", ik_dh_dyn_in[35:0]); else n_pass++;
      bus_read(6'h00, rd);
      n_total++;
      if (rd !== 32'h1) $display("FAIL status_busy: got %h want 1", rd); else n_pass++;
      repeat (16) @(negedge clk);
      n_total++;
      if (ik_en !== 1'b1) $display("FAIL busy_en_c20: got %b want 1", ik_en); else n_pass++;
      ik_done = 1'b1;
      @(negedge clk);
      ik_done = 1'b0;
      n_total++;
      if (ik_en !== 1'b0) $display("FAIL busy_en_after_done: got %b want 0", ik_en); else n_pass++;
      bus_read(6'h38, rd);
      n_total++;
      if (rd !== 32'd20) $display("FAIL cycles_not_restarted: got %0d want 20", rd); else n_pass++;
      bus_read(6'h08, rd);
      n_total++;
      if (rd !== 32'hAAAA_5555) $display("FAIL dh_in0_read: got %h want AAAA5555", rd); else n_pass++;
   endtask

   task automatic test_timeout();
      bus_write(6'h00, 32'h1);
      repeat (MAXC - 1) @(negedge clk);
      n_total++;
      if ({ik_en, ik_rst} !== 2'b10) $display("FAIL to_last_run: got en,rst=%b want 10", {ik_en, ik_rst}); else n_pass++;
      @(negedge clk);
      n_total++;
      if ({ik_en, ik_rst} !== 2'b01) $display("FAIL to_rst_c1: got en,rst=%b want 01", {ik_en, ik_rst}); else n_pass++;
      @(negedge clk);
      n_total++;
      if (ik_rst !== 1'b1) $display("FAIL to_rst_c2: got %b want 1", ik_rst); else n_pass++;
      @(negedge clk);
      n_total++;
      if (ik_rst !== 1'b0) $display("FAIL to_rst_end: got %b want 0", ik_rst); else n_pass++;
      bus_read(6'h00, rd);
      n_total++;
      if (rd !== 32'h4) $display("FAIL status_timeout: got %h want 4", rd); else n_pass++;
   endtask

   task automatic test_soft_reset_vs_done();
      bus_write(6'h00, 32'h1);
      repeat (9) @(negedge clk);
      ik_dh_dyn_out[0 +: DW] = 36'h0_5555_AAAA;
      ik_done = 1'b1;
      bus_write(6'h00, 32'h2);
      ik_done = 1'b0;
      n_total++;
      if ({ik_en, ik_rst} !== 2'b01) $display("FAIL srst_c1: got en,rst=%b want 01", {ik_en, ik_rst}); else n_pass++;
      @(negedge clk);
      n_total++;
      if (ik_rst !== 1'b1) $display("FAIL srst_c2: got %b want 1", ik_rst); else n_pass++;
      @(negedge clk);
      n_total++;
      if (ik_rst !== 1'b0) $display("FAIL srst_end: got %b want 0", ik_rst); else n_pass++;
      bus_read(6'h00, rd);
      n_total++;
      if (rd !== 32'h0) $display("FAIL srst_status: got %h want 0", rd); else n_pass++;
      bus_read(6'h20, rd);
      n_total++;
      if (rd !== 32'h0000_0001) $display("FAIL srst_no_capture: got %h want 00000001", rd); else n_pass++;
      bus_read(6'h38, rd);
      n_total++;
      if (rd !== 32'd20) $display("FAIL srst_cycles_kept: got %0d want 20", rd); else n_pass++;
   endtask

   task automatic test_clear_vs_done();
      bus_write(6'h00, 32'h1);
      repeat (4) @(negedge clk);
      ik_done = 1'b1;
      bus_write(6'h00, 32'h8);
      ik_done = 1'b0;
      bus_read(6'h00, rd);
      n_total++;
      if (rd !== 32'h2) $display("FAIL clear_vs_done_status: got %h want 2", rd); else n_pass++;
      bus_read(6'h38, rd);
      n_total++;
      if (rd !== 32'd5) $display("FAIL clear_vs_done_cycles: got %0d want 5", rd); else n_pass++;
   endtask

   initial begin
      n_pass        = 0;
      n_total       = 0;
      rst           = 1'b1;
      address       = '0;
      chipselect    = 1'b0;
      write         = 1'b0;
      read          = 1'b0;
      writedata     = '0;
      ik_done       = 1'b0;
      ik_dh_dyn_out = '0;
      ik_delta      = '0;
      test_reset();
      test_operand_write();
      test_run_done();
      test_busy_ignores();
      test_timeout();
      test_soft_reset_vs_done();
      test_clear_vs_done();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
